// File: rtl/hams_pkg.sv
// hams_pkg: shared types for the bitonic sorter and its output serializer.
// `pair` is the 32-bit sort record (key in the upper half, payload in the lower half).
package hams_pkg;

    localparam int NUM_ELEMENTS = 4;

    typedef struct packed {
        logic [15:0] key;
        logic [15:0] val;
    } pair;

    typedef pair [NUM_ELEMENTS-1:0] pair_vec_t;

    localparam int SER_DEPTH = 2;
    localparam int VEC_CNT_W = 16;

    // Vector buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/hams_vec_buf.sv
// hams_vec_buf: two-slot vector store between the sorter and the serializer.
// Head/tail are 1-bit slot pointers. in_ready is registered from the next
// occupancy, so it never depends combinationally on the pop request and is
// low while reset is asserted.
module hams_vec_buf
    import hams_pkg::*;
#(
    parameter int NUM_ELEMENTS = hams_pkg::NUM_ELEMENTS,
    parameter int VEC_W        = NUM_ELEMENTS * $bits(pair)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_data,
    input  logic             pop,
    output logic             not_empty,
    output logic [VEC_W-1:0] head_data
);

    logic [VEC_W-1:0] r_slot [SER_DEPTH];
    logic             r_head;
    logic             r_tail;
    logic             r_in_ready;
    occ_state_t       r_state;
    logic             w_push;

    assign w_push    = in_valid && r_in_ready;
    assign in_ready  = r_in_ready;
    assign not_empty = (r_state != OCC_EMPTY);
    assign head_data = r_slot[r_head];

    // Slot storage, pointers and occupancy FSM with registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SER_DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= OCC_EMPTY;
        end else begin
            if (w_push) begin
                r_slot[r_tail] <= in_data;
                r_tail         <= ~r_tail;
            end
            if (pop) begin
                r_head <= ~r_head;
            end
            r_in_ready <= 1'b1;
            unique case (r_state)
                OCC_EMPTY: begin
                    if (w_push) r_state <= OCC_ONE;
                end
                OCC_ONE: begin
                    if (w_push && !pop) begin
                        r_state    <= OCC_TWO;
                        r_in_ready <= 1'b0;
                    end else if (!w_push && pop) begin
                        r_state <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) r_state    <= OCC_ONE;
                    else     r_in_ready <= 1'b0;
                end
                default: r_state <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/hams_vec_serializer.sv
// hams_vec_serializer: re-emits each sorted vector as one pair per cycle with
// element index, end-of-vector marker and a completed-vector counter.
// Optional macro HAMS_SER_REVERSE_EN: emit elements in descending order.
module hams_vec_serializer
    import hams_pkg::*;
#(
    parameter int NUM_ELEMENTS = hams_pkg::NUM_ELEMENTS,
    parameter int IDX_W        = $clog2(NUM_ELEMENTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_ELEMENTS*$bits(pair)-1:0] in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$bits(pair)-1:0]              out_data,
    output logic [IDX_W-1:0]                    out_idx,
    output logic                                out_last,
    output logic [VEC_CNT_W-1:0]                vec_cnt
);

    logic [IDX_W-1:0]                    r_elem_idx;
    logic [VEC_CNT_W-1:0]                r_vec_cnt;
    logic [NUM_ELEMENTS*$bits(pair)-1:0] w_head_flat;
    pair  [NUM_ELEMENTS-1:0]             w_head_vec;
    logic [IDX_W-1:0]                    w_sel;
    logic                                w_xfer;
    logic                                w_pop;

    hams_vec_buf #(
        .NUM_ELEMENTS (NUM_ELEMENTS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pop       (w_pop),
        .not_empty (out_valid),
        .head_data (w_head_flat)
    );

`ifdef HAMS_SER_REVERSE_EN
    assign w_sel = IDX_W'(NUM_ELEMENTS - 1) - r_elem_idx;
`else
    assign w_sel = r_elem_idx;
`endif

    assign w_head_vec = w_head_flat;
    assign out_data   = w_head_vec[w_sel];
    assign out_idx    = r_elem_idx;
    assign out_last   = (r_elem_idx == IDX_W'(NUM_ELEMENTS - 1));
    assign vec_cnt    = r_vec_cnt;
    assign w_xfer     = out_valid && out_ready;
    assign w_pop      = w_xfer && out_last;

    // Element counter and completed-vector counter advance on output transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem_idx <= '0;
            r_vec_cnt  <= '0;
        end else if (w_xfer) begin
            if (out_last) begin
                r_elem_idx <= '0;
                r_vec_cnt  <= r_vec_cnt + 1'b1;
            end else begin
                r_elem_idx <= r_elem_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hams_vec_serializer.sv
// Testbench for hams_vec_serializer: table-driven single vectors, hand-written
// corner sequences and a randomized phase checked by a queue-based model.
module tb_hams_vec_serializer;
    import hams_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*32-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_data;
    logic [1:0]      out_idx;
    logic            out_last;
    logic [15:0]     vec_cnt;

    hams_vec_serializer #(.NUM_ELEMENTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Expected k-th emitted element of vector v
    function automatic logic [31:0] exp_elem(input logic [N*32-1:0] v, input int k);
`ifdef HAMS_SER_REVERSE_EN
        return v[(N-1-k)*32 +: 32];
`else
        return v[k*32 +: 32];
`endif
    endfunction

    // ---------------- reference model ----------------
    bit          chk_en = 1'b0;
    bit          m_live = 1'b0;
    int          m_occ  = 0;
    int          m_pos  = 0;
    logic [15:0] m_vc   = '0;
    logic [15:0] vc_off = '0;
    logic [31:0] m_q[$];

    always @(posedge clk) m_live = !rst;

    always @(negedge clk) begin
        bit          exp_rdy;
        bit          do_pop;
        bit          do_push;
        logic [31:0] tmp;
        if (rst) begin
            m_q.delete();
            m_occ = 0;
            m_pos = 0;
            m_vc  = '0;
        end else if (chk_en) begin
            exp_rdy = m_live && (m_occ < 2);
            chk("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("mon_out_valid", 32'(out_valid), 32'(m_occ > 0));
            chk("mon_vec_cnt", 32'(vec_cnt), 32'(16'(m_vc + vc_off)));
            if (m_occ > 0) begin
                chk("mon_out_data", out_data, m_q[0]);
                chk("mon_out_idx", 32'(out_idx), 32'(m_pos));
                chk("mon_out_last", 32'(out_last), 32'(m_pos == N-1));
            end
            do_pop  = out_ready && (m_occ > 0);
            do_push = in_valid && exp_rdy;
            if (do_pop) begin
                tmp = m_q.pop_front();
                m_pos++;
                if (m_pos == N) begin
                    m_pos = 0;
                    m_occ--;
                    m_vc = m_vc + 16'd1;
                end
            end
            if (do_push) begin
                for (int k = 0; k < N; k++) m_q.push_back(exp_elem(in_data, k));
                m_occ++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_vec(input logic [N*32-1:0] v);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 32'(out_valid), 32'd0);
    endtask

    function automatic logic [N*32-1:0] rand_vec();
        logic [N*32-1:0] v;
        for (int k = 0; k < N; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    typedef struct {
        logic [N*32-1:0] vin;
        logic [31:0]     exp [N];
    } vec_rec_t;

    vec_rec_t tbl [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [N*32-1:0] va;
        logic [N*32-1:0] vb;

        // table: element 0 at LSBs
        tbl[0].vin = {32'h44, 32'h33, 32'h22, 32'h11};
        tbl[1].vin = {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2].vin = {32'h8000_0001, 32'h4000_0002, 32'h2000_0004, 32'h1000_0008};
        tbl[3].vin = {32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D, 32'h0BAD_F00D};
`ifdef HAMS_SER_REVERSE_EN
        tbl[0].exp = '{32'h44, 32'h33, 32'h22, 32'h11};
        tbl[1].exp = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2].exp = '{32'h8000_0001, 32'h4000_0002, 32'h2000_0004, 32'h1000_0008};
        tbl[3].exp = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D, 32'h0BAD_F00D};
`else
        tbl[0].exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        tbl[1].exp = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[2].exp = '{32'h1000_0008, 32'h2000_0004, 32'h4000_0002, 32'h8000_0001};
        tbl[3].exp = '{32'h0BAD_F00D, 32'hCAFE_F00D, 32'h0123_4567, 32'hDEAD_BEEF};
`endif

        // reset state
        chk_en = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // table-driven single vectors at full rate
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            push_vec(tbl[t].vin);
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                chk("tbl_valid", 32'(out_valid), 32'd1);
                chk("tbl_data", out_data, tbl[t].exp[k]);
                chk("tbl_idx", 32'(out_idx), 32'(k));
                chk("tbl_last", 32'(out_last), 32'(k == N-1));
                @(posedge clk);
                #1;
            end
            chk("tbl_idle", 32'(out_valid), 32'd0);
        end
        chk("tbl_vec_cnt", 32'(vec_cnt), 32'd4);

        // back-to-back: three vectors, 12 transfers without a bubble
        fork
            begin
                for (int t = 0; t < 3; t++) push_vec(rand_vec());
            end
            begin
                int first;
                int last;
                int cyc;
                int n;
                first = -1;
                last  = -1;
                cyc   = 0;
                n     = 0;
                while (n < 3*N && cyc < 60) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (first < 0) first = cyc;
                        last = cyc;
                        n++;
                    end
                    cyc++;
                end
                chk("b2b_count", 32'(n), 32'(3*N));
                chk("b2b_span", 32'(last - first), 32'(3*N - 1));
            end
        join
        drain();
        chk("b2b_vec_cnt", 32'(vec_cnt), 32'd7);

        // back-pressure with both slots full
        out_ready = 1'b0;
        va = rand_vec();
        vb = rand_vec();
        push_vec(va);
        push_vec(vb);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, exp_elem(va, 0));
            chk("bp_idx", 32'(out_idx), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("bp_rel_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_rel_data", out_data, exp_elem(va, k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_rel_in_ready_high", 32'(in_ready), 32'd1);
        chk("bp_next_vec", out_data, exp_elem(vb, 0));
        @(posedge clk);
        #1;
        drain();
        chk("bp_vec_cnt", 32'(vec_cnt), 32'd9);

        // push coinciding with the last-element pop in state ONE
        va = rand_vec();
        vb = rand_vec();
        push_vec(va);
        for (int k = 1; k < N; k++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = vb;
        @(negedge clk);
        chk("sim_last", 32'(out_last), 32'd1);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_idx", 32'(out_idx), 32'd0);
        chk("sim_data", out_data, exp_elem(vb, 0));
        chk("sim_in_ready_one", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("sim_vec_cnt", 32'(vec_cnt), 32'd11);

        // vec_cnt wrap from a preloaded value
        chk_en = 1'b0;
        force dut.r_vec_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_vec_cnt;
        vc_off = 16'hFFFE - m_vc;
        chk_en = 1'b1;
        push_vec(rand_vec());
        drain();
        chk("wrap_ffff", 32'(vec_cnt), 32'h0000_FFFF);
        push_vec(rand_vec());
        drain();
        chk("wrap_zero", 32'(vec_cnt), 32'd0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = rand_vec();
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        push_vec(rand_vec());
        push_vec(rand_vec());
        @(posedge clk);
        #3;
        rst    = 1'b1;
        vc_off = '0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("mrst_out_idx", 32'(out_idx), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst_in_ready_post", 32'(in_ready), 32'd1);
        chk("mrst_no_stale", 32'(out_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
        end
        push_vec(tbl[0].vin);
        drain();
        chk("mrst_vec_cnt_after", 32'(vec_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
